hazard_scoreboard_unit: RTL and testbench

- Parametrised successor to the pipeline hazard unit. Replaces fixed load-use/JR address compares with a per-register countdown scoreboard.
- Supports producers of arbitrary latency: ALU, load, multi-cycle mul/div.
- Combines data stalls with EX-resolved branch flush, ID jump redirect and a global memory freeze.
- Sits beside the 5-stage datapath. Drives PC source/write and the per-stage write/flush controls.

---
 rtl/hazard_scoreboard_unit.sv | 149 ++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Countdown-scoreboard hazard unit: data stalls, branch/jump redirect, memory freeze.
// Optional perf counters enabled by HAZARD_SB_PERF_CNT_EN.
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int MAX_LAT    = 7,
    parameter int EX_SLACK   = 1,
    parameter int CNT_W      = $clog2(MAX_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    input  logic                  id_dst_wen,
    input  logic [CNT_W-1:0]      id_dst_lat,
    input  logic [1:0]            id_pc_src,
    input  logic                  ex_branch_taken,
    input  logic                  mem_stall,
    output logic [1:0]            pc_src,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_write,
    output logic                  exmem_write,
    output logic                  memwb_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  sb_busy
`ifdef HAZARD_SB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    localparam logic [CNT_W-1:0] SLACK = CNT_W'(EX_SLACK);
    localparam logic [CNT_W-1:0] MAXV  = CNT_W'(MAX_LAT);

    logic [CNT_W-1:0] cnt_q [NUM_REGS];

    logic [CNT_W-1:0] rs_cnt, rt_cnt, lat_sat;
    logic rs_haz, rt_haz, is_jr, is_jump, data_stall;
    logic br_case, stall_case, jump_case, issue;

    assign rs_cnt  = cnt_q[id_rs_addr];
    assign rt_cnt  = cnt_q[id_rt_addr];
    assign is_jr   = (id_pc_src == 2'b10);
    assign is_jump = id_valid &&
                     (id_pc_src == 2'b01 || id_pc_src == 2'b10);

    // JR reads rs in ID, so it cannot use the forwarding slack.
    assign rs_haz = id_uses_rs && (id_rs_addr != '0) &&
                    (is_jr ? (rs_cnt != '0) : (rs_cnt > SLACK));
    assign rt_haz = id_uses_rt && (id_rt_addr != '0) &&
                    (rt_cnt > SLACK);

    assign data_stall = id_valid && (rs_haz || rt_haz);

    assign br_case    = !mem_stall && ex_branch_taken;
    assign stall_case = !mem_stall && !ex_branch_taken && data_stall;
    assign jump_case  = !mem_stall && !ex_branch_taken &&
                        !data_stall && is_jump;

    assign issue = !mem_stall && !ex_branch_taken && !data_stall &&
                   id_valid && id_dst_wen && (id_dst_addr != '0);

    assign lat_sat = (id_dst_lat > MAXV) ? MAXV : id_dst_lat;

    always_comb begin
        pc_src      = 2'b00;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        memwb_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        if (mem_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
        end else if (ex_branch_taken) begin
            pc_src     = 2'b11;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (data_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end else if (is_jump) begin
            pc_src     = id_pc_src;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else if (!mem_stall) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue && id_dst_addr == REG_ADDR_W'(r)) begin
                    cnt_q[r] <= lat_sat;
                end else if (cnt_q[r] != '0) begin
                    cnt_q[r] <= cnt_q[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        sb_busy = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            sb_busy = sb_busy | (cnt_q[r] != '0);
        end
    end

`ifdef HAZARD_SB_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_case && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if ((br_case || jump_case) && perf_flush_q != '1) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    logic unused_perf;
    assign unused_perf = br_case ^ stall_case ^ jump_case;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed scoreboard bench for hazard_scoreboard_unit.
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs_addr, id_rt_addr, id_dst_addr;
    logic       id_uses_rs, id_uses_rt, id_dst_wen;
    logic [2:0] id_dst_lat;
    logic [1:0] id_pc_src;
    logic       ex_branch_taken, mem_stall;
    logic [1:0] pc_src;
    logic       pc_write, ifid_write, idex_write;
    logic       exmem_write, memwb_write;
    logic       ifid_flush, idex_flush, sb_busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    exp_t sbq[$];

    // {pc_write, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f}
    localparam logic [6:0] FRZ = 7'b0000000;
    localparam logic [6:0] BR  = 7'b1011111;
    localparam logic [6:0] STL = 7'b0011101;
    localparam logic [6:0] JMP = 7'b1111110;
    localparam logic [6:0] NRM = 7'b1111100;

    always #5 clk = ~clk;

    hazard_scoreboard_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_dst_addr     (id_dst_addr),
        .id_dst_wen      (id_dst_wen),
        .id_dst_lat      (id_dst_lat),
        .id_pc_src       (id_pc_src),
        .ex_branch_taken (ex_branch_taken),
        .mem_stall       (mem_stall),
        .pc_src          (pc_src),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .exmem_write     (exmem_write),
        .memwb_write     (memwb_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .sb_busy         (sb_busy)
    );

    function automatic logic [9:0] e(input logic [1:0] ps,
                                     input logic [6:0] ctl,
                                     input logic busy);
        return {ps, ctl, busy};
    endfunction

    task automatic idle();
        id_valid        = 1'b0;
        id_rs_addr      = '0;
        id_rt_addr      = '0;
        id_uses_rs      = 1'b0;
        id_uses_rt      = 1'b0;
        id_dst_addr     = '0;
        id_dst_wen      = 1'b0;
        id_dst_lat      = '0;
        id_pc_src       = 2'b00;
        ex_branch_taken = 1'b0;
        mem_stall       = 1'b0;
    endtask

    task automatic instr(input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic [4:0] dst, input logic wen,
                         input logic [2:0] lat, input logic [1:0] ps);
        idle();
        id_valid    = 1'b1;
        id_rs_addr  = rs;
        id_uses_rs  = urs;
        id_rt_addr  = rt;
        id_uses_rt  = urt;
        id_dst_addr = dst;
        id_dst_wen  = wen;
        id_dst_lat  = lat;
        id_pc_src   = ps;
    endtask

    // Push expectation with the stimulus, pop it when outputs settle,
    // then advance to just after the next rising edge.
    task automatic chk(input string tag, input logic [9:0] v);
        exp_t x;
        logic [9:0] obs;
        x.tag = tag;
        x.v   = v;
        sbq.push_back(x);
        #3;
        x = sbq.pop_front();
        obs = {pc_src, pc_write, ifid_write, idex_write,
               exmem_write, memwb_write, ifid_flush,
               idex_flush, sb_busy};
        checks++;
        assert (obs === x.v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b",
                   x.tag, obs, x.v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #1;
        chk("reset", e(2'b00, NRM, 1'b0));
        rst_n = 1'b1;

        // Load r8 lat 3, dependent add next cycle
        instr(0, 0, 0, 0, 8, 1, 3, 2'b00);
        chk("ld_r8", e(2'b00, NRM, 1'b0));
        instr(8, 1, 0, 0, 10, 1, 1, 2'b00);
        chk("add_stall_c3", e(2'b00, STL, 1'b1));
        chk("add_stall_c2", e(2'b00, STL, 1'b1));
        chk("add_issue_c1", e(2'b00, NRM, 1'b1));
        idle();
        chk("drain_r10", e(2'b00, NRM, 1'b1));
        chk("idle_empty", e(2'b00, NRM, 1'b0));

        // mul r9 lat 6, JR r9 immediately
        instr(0, 0, 0, 0, 9, 1, 6, 2'b00);
        chk("mul_r9", e(2'b00, NRM, 1'b0));
        instr(9, 1, 0, 0, 0, 0, 0, 2'b10);
        for (int i = 0; i < 6; i++) begin
            chk("jr_r9_stall", e(2'b00, STL, 1'b1));
        end
        chk("jr_r9_go", e(2'b10, JMP, 1'b0));
        instr(0, 0, 0, 0, 0, 0, 0, 2'b01);
        chk("jump", e(2'b01, JMP, 1'b0));
        instr(0, 0, 0, 0, 0, 0, 0, 2'b11);
        chk("pcsrc_rsvd", e(2'b00, NRM, 1'b0));

        // cnt=1: JR must wait, EX reader within slack must not
        instr(0, 0, 0, 0, 11, 1, 1, 2'b00);
        chk("r11_lat1", e(2'b00, NRM, 1'b0));
        instr(11, 1, 0, 0, 0, 0, 0, 2'b10);
        chk("jr_r11_stall", e(2'b00, STL, 1'b1));
        chk("jr_r11_go", e(2'b10, JMP, 1'b0));
        instr(0, 0, 0, 0, 13, 1, 1, 2'b00);
        chk("r13_lat1", e(2'b00, NRM, 1'b0));
        instr(13, 1, 0, 0, 0, 0, 0, 2'b00);
        chk("ex_slack_ok", e(2'b00, NRM, 1'b1));
        idle();
        chk("slack_drain", e(2'b00, NRM, 1'b0));

        // Branch beats a data stall; stalled dst r12 not issued
        instr(0, 0, 0, 0, 7, 1, 4, 2'b00);
        chk("r7_lat4", e(2'b00, NRM, 1'b0));
        instr(7, 1, 0, 0, 12, 1, 5, 2'b00);
        ex_branch_taken = 1'b1;
        chk("br_over_stall", e(2'b11, BR, 1'b1));
        idle();
        chk("br_d1", e(2'b00, NRM, 1'b1));
        chk("br_d2", e(2'b00, NRM, 1'b1));
        chk("br_d3", e(2'b00, NRM, 1'b1));
        chk("br_no_issue", e(2'b00, NRM, 1'b0));

        // mem_stall freeze for 4 cycles with r5 pending
        instr(0, 0, 0, 0, 5, 1, 2, 2'b00);
        chk("r5_lat2", e(2'b00, NRM, 1'b0));
        instr(5, 1, 0, 0, 6, 1, 7, 2'b00);
        mem_stall = 1'b1;
        chk("frz0", e(2'b00, FRZ, 1'b1));
        ex_branch_taken = 1'b1;
        chk("frz1_br", e(2'b00, FRZ, 1'b1));
        ex_branch_taken = 1'b0;
        chk("frz2", e(2'b00, FRZ, 1'b1));
        chk("frz3", e(2'b00, FRZ, 1'b1));
        instr(5, 1, 0, 0, 0, 0, 0, 2'b00);
        chk("r5_held_stall", e(2'b00, STL, 1'b1));
        chk("r5_go", e(2'b00, NRM, 1'b1));
        idle();
        chk("r5_drain", e(2'b00, NRM, 1'b0));

        // r0 never tracked; r3 at MAX_LAT
        instr(0, 0, 0, 0, 0, 1, 5, 2'b00);
        chk("r0_write", e(2'b00, NRM, 1'b0));
        instr(0, 1, 0, 1, 0, 0, 0, 2'b00);
        chk("r0_read", e(2'b00, NRM, 1'b0));
        instr(0, 1, 0, 0, 0, 0, 0, 2'b10);
        chk("jr_r0", e(2'b10, JMP, 1'b0));
        instr(0, 0, 0, 0, 3, 1, 7, 2'b00);
        chk("r3_lat7", e(2'b00, NRM, 1'b0));
        instr(0, 0, 3, 1, 0, 0, 0, 2'b00);
        for (int i = 0; i < 6; i++) begin
            chk("r3_stall", e(2'b00, STL, 1'b1));
        end
        chk("r3_go", e(2'b00, NRM, 1'b1));
        idle();
        chk("r3_drain", e(2'b00, NRM, 1'b0));

        // Async reset with r4 pending
        instr(0, 0, 0, 0, 4, 1, 4, 2'b00);
        chk("r4_lat4", e(2'b00, NRM, 1'b0));
        idle();
        rst_n = 1'b0;
        chk("async_rst", e(2'b00, NRM, 1'b0));
        rst_n = 1'b1;
        instr(4, 1, 0, 0, 0, 0, 0, 2'b00);
        chk("r4_after_rst", e(2'b00, NRM, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
